alu_result_serializer: RTL

//  Output half of the ALU serial link: takes one parallel ALU response and serializes it on sout
//  as 11-bit frames, one bit per clk. A frame is start(0), type, data[7:0] MSB first, stop(1).
//  A result packet is 4 DATA frames carrying C, MSB byte first, then 1 CTL frame {0,flags,crc3}.
//  An error packet is 1 CTL frame {1,err_flags[5:0],parity}. Sits between ALU core and sout pin.

---
 rtl/alu_ser_pkg.sv | 40 ++++
 rtl/alu_frame_tx.sv | 71 +++++++
 rtl/alu_result_serializer.sv | 102 ++++++++++
 3 files changed

// File: rtl/alu_ser_pkg.sv
// rtl/alu_ser_pkg.sv - shared types, frame constants and CRC-3 for the ALU result serializer
package alu_ser_pkg;

   localparam logic FRAME_DATA = 1'b0;
   localparam logic FRAME_CTL  = 1'b1;
   localparam int   FRAME_BITS = 11;

   localparam int FLAG_N = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_O = 2;
   localparam int FLAG_C = 3;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_TYPE,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef struct packed {
      logic        err;
      logic [31:0] c;
      logic [3:0]  flags;
      logic [5:0]  eflags;
   } pkt_t;

   // x^3+x+1, init 0, d[36] enters first; the loop unrolls into a flat XOR network.
   function automatic logic [2:0] crc3_37(input logic [36:0] d);
      logic [2:0] crc;
      logic       fb;
      crc = 3'b000;
      for (int i = 36; i >= 0; i--) begin
         fb  = crc[2] ^ d[i];
         crc = {crc[1], crc[0] ^ fb, fb};
      end
      return crc;
   endfunction

endpackage

// File: rtl/alu_frame_tx.sv
// rtl/alu_frame_tx.sv - single 11-bit frame shifter: start, type, byte MSB first, stop
module alu_frame_tx
   import alu_ser_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       go,
   input  logic       frame_type,
   input  logic [7:0] frame_byte,
   output logic       sout_bit,
   output logic       done
);

   tx_state_t  state;
   logic [2:0] bit_cnt;
   logic [7:0] shreg;
   logic       type_q;

   // go is honoured in IDLE or in the stop-bit cycle, giving back-to-back frames.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= TX_IDLE;
         bit_cnt  <= 3'd0;
         shreg    <= 8'h00;
         type_q   <= 1'b0;
         sout_bit <= 1'b1;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (go) begin
            state    <= TX_START;
            shreg    <= frame_byte;
            type_q   <= frame_type;
            sout_bit <= 1'b0;
         end else begin
            case (state)
               TX_START: begin
                  state    <= TX_TYPE;
                  sout_bit <= type_q;
               end
               TX_TYPE: begin
                  state    <= TX_DATA;
                  bit_cnt  <= 3'd7;
                  sout_bit <= shreg[7];
                  shreg    <= {shreg[6:0], 1'b0};
               end
               TX_DATA: begin
                  if (bit_cnt == 3'd0) begin
                     state    <= TX_STOP;
                     sout_bit <= 1'b1;
                     done     <= 1'b1;
                  end else begin
                     bit_cnt  <= bit_cnt - 3'd1;
                     sout_bit <= shreg[7];
                     shreg    <= {shreg[6:0], 1'b0};
                  end
               end
               TX_STOP: begin
                  state    <= TX_IDLE;
                  sout_bit <= 1'b1;
               end
               default: begin
                  state    <= TX_IDLE;
                  sout_bit <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/alu_result_serializer.sv
// rtl/alu_result_serializer.sv - serializes ALU result/error responses into framed packets on sout
// Optional 1-entry input skid buffer enabled by defining ALU_SER_SKID_EN.
module alu_result_serializer
   import alu_ser_pkg::*;
#(
   parameter int DATA_BYTES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_err,
   input  logic [31:0] in_c,
   input  logic [3:0]  in_flags,
   input  logic [5:0]  in_err_flags,
   output logic        sout,
   output logic        busy
);

   localparam logic [2:0] LAST_IDX = 3'(DATA_BYTES);

   pkt_t       in_pkt, cur_pkt, buf_pkt, go_pkt;
   logic [2:0] idx, go_idx;
   logic       xfer, last_frame, frame_done, pkt_end;
   logic       start_from_buf, start_from_in, start, go, go_type;
   logic [7:0] go_byte;
   logic [31:0] c_sh;

   assign in_pkt     = '{err: in_err, c: in_c, flags: in_flags, eflags: in_err_flags};
   assign xfer       = in_valid && in_ready;
   assign last_frame = cur_pkt.err || (idx == LAST_IDX);
   assign pkt_end    = busy && frame_done && last_frame;
   assign start      = start_from_buf || start_from_in;
   assign go         = start || (busy && frame_done && !last_frame);
   assign go_pkt     = start_from_buf ? buf_pkt : (start ? in_pkt : cur_pkt);
   assign go_idx     = start ? 3'd0 : idx + 3'd1;

`ifdef ALU_SER_SKID_EN
   logic buf_full;

   assign in_ready       = !rst && !buf_full;
   assign start_from_buf = buf_full && pkt_end;
   // Direct start whenever the line is free at this edge; otherwise park in the buffer.
   assign start_from_in  = xfer && !buf_full && (!busy || pkt_end);

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_full <= 1'b0;
         buf_pkt  <= '0;
      end else if (start_from_buf) begin
         buf_full <= 1'b0;
      end else if (xfer && !start_from_in) begin
         buf_full <= 1'b1;
         buf_pkt  <= in_pkt;
      end
   end
`else
   assign in_ready       = !rst && !busy;
   assign start_from_buf = 1'b0;
   assign start_from_in  = xfer;
   assign buf_pkt        = '0;
`endif

   // Byte for the frame launched at this edge: DATA bytes MSB first, then the CTL byte.
   always_comb begin
      c_sh    = go_pkt.c << {go_idx, 3'b000};
      go_type = FRAME_DATA;
      go_byte = c_sh[31:24];
      if (go_pkt.err) begin
         go_type = FRAME_CTL;
         go_byte = {1'b1, go_pkt.eflags, ^{1'b1, go_pkt.eflags}};
      end else if (go_idx == LAST_IDX) begin
         go_type = FRAME_CTL;
         go_byte = {1'b0, go_pkt.flags, crc3_37({go_pkt.c, 1'b0, go_pkt.flags})};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy    <= 1'b0;
         idx     <= 3'd0;
         cur_pkt <= '0;
      end else if (go) begin
         busy    <= 1'b1;
         idx     <= go_idx;
         cur_pkt <= go_pkt;
      end else if (pkt_end) begin
         busy <= 1'b0;
      end
   end

   alu_frame_tx u_frame_tx (
      .clk        (clk),
      .rst        (rst),
      .go         (go),
      .frame_type (go_type),
      .frame_byte (go_byte),
      .sout_bit   (sout),
      .done       (frame_done)
   );

endmodule
